// File: rtl/wb_port_arbiter_if.sv
// Bundle of register-file write-port signals shared by the pipeline writeback,
// the multiply/divide unit and the decode-stage hazard check.
interface wb_port_arbiter_if #(
    parameter int n = 32
);
    logic         pipe_wb_en;
    logic [4:0]   pipe_dest;
    logic [n-1:0] pipe_value;
    logic         md_valid;
    logic         md_ready;
    logic [4:0]   md_dest;
    logic [n-1:0] md_value;
    logic [4:0]   src1;
    logic [4:0]   src2;
    logic         hazard_stall;
    logic         WB_en;
    logic [4:0]   dest;
    logic [n-1:0] WB_value;

    modport master (
        output pipe_wb_en, pipe_dest, pipe_value,
        output md_valid, md_dest, md_value,
        output src1, src2,
        input  md_ready, hazard_stall,
        input  WB_en, dest, WB_value
    );

    modport slave (
        input  pipe_wb_en, pipe_dest, pipe_value,
        input  md_valid, md_dest, md_value,
        input  src1, src2,
        output md_ready, hazard_stall,
        output WB_en, dest, WB_value
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, multiply/divide results
// wait in a 2-entry FIFO, younger pipeline writes squash buffered results (WAW).
module wb_port_arbiter #(
    parameter int n = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    logic         live   [2];
    logic [4:0]   edest  [2];
    logic [n-1:0] evalue [2];
    logic         head;
    logic [1:0]   count;

    logic         pipe_eff;
    logic         accept;
    logic         pop;
    logic         tail;
    logic         md_live;
    logic [1:0]   occ;
    logic         haz;

    assign pipe_eff = bus.pipe_wb_en && (bus.pipe_dest != 5'd0);
    assign bus.md_ready = (count != 2'd2) && !rst;
    assign accept   = bus.md_valid && bus.md_ready;
    assign pop      = !pipe_eff && (count != 2'd0);
    // Only used when count < 2, so the free slot sits just past the head.
    assign tail     = head ^ count[0];
    assign md_live  = (bus.md_dest != 5'd0) &&
                      !(pipe_eff && (bus.pipe_dest == bus.md_dest));

    assign occ[0] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b0));
    assign occ[1] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b1));

    always_comb begin
        haz = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (occ[i[0]] && live[i[0]]) begin
                if ((bus.src1 != 5'd0) && (edest[i[0]] == bus.src1)) haz = 1'b1;
                if ((bus.src2 != 5'd0) && (edest[i[0]] == bus.src2)) haz = 1'b1;
            end
        end
    end
    assign bus.hazard_stall = haz;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.WB_en    <= 1'b0;
            bus.dest     <= '0;
            bus.WB_value <= '0;
            head         <= 1'b0;
            count        <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                live[i[0]]   <= 1'b0;
                edest[i[0]]  <= '0;
                evalue[i[0]] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (pipe_eff && (edest[i[0]] == bus.pipe_dest)) live[i[0]] <= 1'b0;
            end
            // The tail slot is free, so this never collides with a squash above.
            if (accept) begin
                live[tail]   <= md_live;
                edest[tail]  <= bus.md_dest;
                evalue[tail] <= bus.md_value;
            end

            if (pipe_eff) begin
                bus.WB_en    <= 1'b1;
                bus.dest     <= bus.pipe_dest;
                bus.WB_value <= bus.pipe_value;
            end else if (pop) begin
                bus.WB_en    <= live[head];
                bus.dest     <= edest[head];
                bus.WB_value <= evalue[head];
            end else begin
                bus.WB_en    <= 1'b0;
            end

            head  <= head ^ pop;
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model checked
// every cycle, plus literal expectations for the planned scenarios.
module tb_wb_port_arbiter;
    localparam int n = 32;

    logic clk;
    logic rst;

    wb_port_arbiter_if #(.n(n)) bus ();

    wb_port_arbiter #(.n(n)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         live;
        logic [4:0]   dest;
        logic [n-1:0] value;
    } entry_t;

    entry_t       q[$];
    logic         m_en;
    logic [4:0]   m_dest;
    logic [n-1:0] m_val;

    int total;
    int bad;

    logic [n-1:0] rf [32];

    // Reference model: buffered results are a plain FIFO queue.
    always @(posedge clk) begin
        entry_t e;
        logic eff;
        logic acc;
        if (rst) begin
            q.delete();
            m_en   = 1'b0;
            m_dest = '0;
            m_val  = '0;
        end else begin
            eff = bus.pipe_wb_en && (bus.pipe_dest != 5'd0);
            acc = bus.md_valid && (q.size() < 2);
            if (eff) begin
                foreach (q[i]) if (q[i].dest == bus.pipe_dest) q[i].live = 1'b0;
                m_en   = 1'b1;
                m_dest = bus.pipe_dest;
                m_val  = bus.pipe_value;
            end else if (q.size() > 0) begin
                e      = q.pop_front();
                m_en   = e.live;
                m_dest = e.dest;
                m_val  = e.value;
            end else begin
                m_en = 1'b0;
            end
            if (acc) begin
                e.live  = (bus.md_dest != 5'd0) && !(eff && (bus.pipe_dest == bus.md_dest));
                e.dest  = bus.md_dest;
                e.value = bus.md_value;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.WB_en === 1'b1) rf[bus.dest] <= bus.WB_value;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        logic h;
        h = 1'b0;
        foreach (q[i]) begin
            if (q[i].live && (bus.src1 != 5'd0) && (q[i].dest == bus.src1)) h = 1'b1;
            if (q[i].live && (bus.src2 != 5'd0) && (q[i].dest == bus.src2)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic compare_all();
        check("cyc WB_en", 64'(bus.WB_en), 64'(m_en));
        check("cyc dest", 64'(bus.dest), 64'(m_dest));
        check("cyc WB_value", 64'(bus.WB_value), 64'(m_val));
        check("cyc md_ready", 64'(bus.md_ready), 64'(!rst && (q.size() < 2)));
        check("cyc hazard_stall", 64'(bus.hazard_stall), 64'(model_hazard()));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic pipe(input logic en, input logic [4:0] d, input logic [n-1:0] v);
        bus.pipe_wb_en = en;
        bus.pipe_dest  = d;
        bus.pipe_value = v;
    endtask

    task automatic md(input logic vld, input logic [4:0] d, input logic [n-1:0] v);
        bus.md_valid = vld;
        bus.md_dest  = d;
        bus.md_value = v;
    endtask

    task automatic port(input string name, input logic en, input logic [4:0] d, input logic [n-1:0] v);
        check({name, " WB_en"}, 64'(bus.WB_en), 64'(en));
        if (en) begin
            check({name, " dest"}, 64'(bus.dest), 64'(d));
            check({name, " WB_value"}, 64'(bus.WB_value), 64'(v));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_en  = 1'b0;
        m_dest = '0;
        m_val = '0;
        foreach (rf[i]) rf[i] = '0;
        rst = 1'b1;
        pipe(1'b0, 5'd0, '0);
        md(1'b1, 5'd5, 32'h1);
        bus.src1 = 5'd0;
        bus.src2 = 5'd0;

        // Reset held two cycles with md_valid asserted
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst WB_en", 64'(bus.WB_en), 64'd0);
            check("rst dest", 64'(bus.dest), 64'd0);
            check("rst WB_value", 64'(bus.WB_value), 64'd0);
            check("rst md_ready", 64'(bus.md_ready), 64'd0);
        end
        rst = 1'b0;
        md(1'b0, 5'd0, '0);
        #1;
        check("post-rst md_ready", 64'(bus.md_ready), 64'd1);

        // Pipeline priority over a buffered md result
        md(1'b1, 5'd5, 32'hAAAA);
        step();
        port("prio accept", 1'b0, 5'd0, '0);
        md(1'b0, 5'd0, '0);
        pipe(1'b1, 5'd7, 32'h1234);
        step();
        port("prio pipe1", 1'b1, 5'd7, 32'h1234);
        step();
        port("prio pipe2", 1'b1, 5'd7, 32'h1234);
        pipe(1'b0, 5'd0, '0);
        step();
        port("prio drain", 1'b1, 5'd5, 32'hAAAA);
        step();
        port("prio idle", 1'b0, 5'd0, '0);
        check("prio dest held", 64'(bus.dest), 64'd5);

        // Full FIFO backpressure
        pipe(1'b1, 5'd1, 32'h11);
        md(1'b1, 5'd3, 32'h333);
        step();
        md(1'b1, 5'd4, 32'h444);
        step();
        check("full md_ready", 64'(bus.md_ready), 64'd0);
        md(1'b1, 5'd6, 32'h666);
        step();
        check("full md_ready held", 64'(bus.md_ready), 64'd0);
        md(1'b0, 5'd0, '0);
        pipe(1'b0, 5'd0, '0);
        step();
        port("bp pop r3", 1'b1, 5'd3, 32'h333);
        check("bp md_ready after pop", 64'(bus.md_ready), 64'd1);
        step();
        port("bp pop r4", 1'b1, 5'd4, 32'h444);
        step();
        port("bp empty", 1'b0, 5'd0, '0);

        // WAW squash of an already buffered entry
        md(1'b1, 5'd9, 32'h55);
        step();
        md(1'b0, 5'd0, '0);
        pipe(1'b1, 5'd9, 32'h77);
        step();
        port("waw pipe r9", 1'b1, 5'd9, 32'h77);
        pipe(1'b0, 5'd0, '0);
        step();
        port("waw squashed pop", 1'b0, 5'd0, '0);

        // Squash of an entry enqueued on the same edge
        md(1'b1, 5'd10, 32'hBAD);
        pipe(1'b1, 5'd10, 32'h10);
        step();
        port("waw same-edge pipe", 1'b1, 5'd10, 32'h10);
        md(1'b0, 5'd0, '0);
        pipe(1'b0, 5'd0, '0);
        step();
        port("waw same-edge pop", 1'b0, 5'd0, '0);
        step();
        check("rf r9", 64'(rf[9]), 64'h77);
        check("rf r10", 64'(rf[10]), 64'h10);

        // Hazard detection against buffered destinations
        pipe(1'b1, 5'd1, 32'h99);
        md(1'b1, 5'd12, 32'hC);
        bus.src1 = 5'd12;
        step();
        check("haz r12", 64'(bus.hazard_stall), 64'd1);
        md(1'b1, 5'd0, 32'h0);
        bus.src1 = 5'd0;
        step();
        check("haz r0 buffered", 64'(bus.hazard_stall), 64'd0);
        md(1'b0, 5'd0, '0);
        bus.src2 = 5'd12;
        step();
        check("haz src2 r12", 64'(bus.hazard_stall), 64'd1);
        pipe(1'b0, 5'd0, '0);
        step();
        port("haz pop r12", 1'b1, 5'd12, 32'hC);
        check("haz after pop", 64'(bus.hazard_stall), 64'd0);
        bus.src2 = 5'd0;
        step();
        port("haz pop r0", 1'b0, 5'd0, '0);

        // Reset with the FIFO full: buffered results are dropped
        pipe(1'b1, 5'd2, 32'h22);
        md(1'b1, 5'd20, 32'h2020);
        step();
        md(1'b1, 5'd21, 32'h2121);
        step();
        check("midrst full md_ready", 64'(bus.md_ready), 64'd0);
        rst = 1'b1;
        pipe(1'b0, 5'd0, '0);
        md(1'b0, 5'd0, '0);
        step();
        port("midrst in reset", 1'b0, 5'd0, '0);
        check("midrst dest", 64'(bus.dest), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            port("midrst no drain", 1'b0, 5'd0, '0);
        end
        check("midrst md_ready", 64'(bus.md_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end
endmodule
